// File: rtl/mips_alu_seq.sv
// mips_alu_seq: clocked EX-stage ALU. Single-cycle integer ops produce a
// registered result one clock after accept; MULTU/DIVU iterate one bit per
// clock into private working registers and commit HI/LO only on completion.
module mips_alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   first_data,
  input  logic [WIDTH-1:0]   second_data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_MFHI = 4'b1110;
  localparam logic [3:0] OP_MFLO = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_accept;
  logic                 w_last_step;

  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_work_hi;   // multiply: product high / divide: remainder
  logic [WIDTH-1:0]     r_work_lo;   // multiply: multiplier / divide: quotient
  logic [WIDTH-1:0]     r_opnd;      // multiplicand or divisor
  logic [SHAMT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero;
  logic                 r_ovf;

  logic [WIDTH-1:0]     w_alu_res;
  logic                 w_alu_ovf;
  logic [WIDTH-1:0]     w_tmp;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_step_hi;
  logic [WIDTH-1:0]     w_step_lo;

  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_step = (r_cnt == SHAMT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; DONE accepts a new request exactly like IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (!start)                 w_next_state = S_IDLE;
        else if (alu_op == OP_MULU) w_next_state = S_MUL;
        else if (alu_op == OP_DIVU) w_next_state = S_DIV;
        else                        w_next_state = S_DONE;
      end
      S_MUL, S_DIV: if (w_last_step) w_next_state = S_DONE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (r_state == S_MUL) || (r_state == S_DIV);
    done = (r_state == S_DONE);
  end

  // Single-cycle operation datapath.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_tmp     = '0;
    case (alu_op)
      OP_AND:  w_alu_res = first_data & second_data;
      OP_OR:   w_alu_res = first_data | second_data;
      OP_XOR:  w_alu_res = first_data ^ second_data;
      OP_NOR:  w_alu_res = ~(first_data | second_data);
      OP_ADD: begin
        w_tmp     = first_data + second_data;
        w_alu_res = w_tmp;
        w_alu_ovf = (first_data[WIDTH-1] == second_data[WIDTH-1]) &&
                    (w_tmp[WIDTH-1] != first_data[WIDTH-1]);
      end
      OP_SUB: begin
        w_tmp     = first_data - second_data;
        w_alu_res = w_tmp;
        w_alu_ovf = (first_data[WIDTH-1] != second_data[WIDTH-1]) &&
                    (w_tmp[WIDTH-1] != first_data[WIDTH-1]);
      end
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(first_data) < $signed(second_data))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (first_data < second_data)};
      OP_SLL:  w_alu_res = second_data << shamt;
      OP_SRL:  w_alu_res = second_data >> shamt;
      OP_SRA:  w_alu_res = $unsigned($signed(second_data) >>> shamt);
      OP_MFHI: w_alu_res = r_hi;
      OP_MFLO: w_alu_res = r_lo;
      default: w_alu_res = '0;
    endcase
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    w_sum     = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_opnd} : '0);
    w_shift   = {r_work_hi, r_work_lo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_opnd};
    w_step_hi = r_work_hi;
    w_step_lo = r_work_lo;
    if (r_state == S_MUL) begin
      {w_step_hi, w_step_lo} = {w_sum, r_work_lo[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      if (!w_diff[WIDTH]) begin
        w_step_hi = w_diff[WIDTH-1:0];
        w_step_lo = {r_work_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_step_hi = w_shift[WIDTH-1:0];
        w_step_lo = {r_work_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Operand capture, iteration and result/HI/LO commit.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_work_hi <= '0;
      r_work_lo <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      case (alu_op)
        OP_MULU: begin
          r_work_hi <= '0;
          r_work_lo <= second_data;
          r_opnd    <= first_data;
        end
        OP_DIVU: begin
          r_work_hi <= '0;
          r_work_lo <= first_data;
          r_opnd    <= second_data;
        end
        default: begin
          r_result <= w_alu_res;
          r_zero   <= (w_alu_res == '0);
          r_ovf    <= w_alu_ovf;
        end
      endcase
    end else if (busy) begin
      r_cnt     <= r_cnt + SHAMT_W'(1);
      r_work_hi <= w_step_hi;
      r_work_lo <= w_step_lo;
      if (w_last_step) begin
        r_hi     <= w_step_hi;
        r_lo     <= w_step_lo;
        r_result <= w_step_lo;
        r_zero   <= (w_step_lo == '0);
        r_ovf    <= 1'b0;
      end
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_mips_alu_seq.sv
// Self-checking bench for mips_alu_seq (WIDTH=32): directed vector table,
// multi-cycle corner sequences and randomized ops against a behavioural model.
module tb_mips_alu_seq;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    alu_op;
  logic [W-1:0]  first_data;
  logic [W-1:0]  second_data;
  logic [4:0]    shamt;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference HI/LO state of the behavioural model.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mips_alu_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op),
    .first_data(first_data), .second_data(second_data), .shamt(shamt),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Behavioural model: plain arithmetic on the operation rules.
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sh, output logic [W-1:0] res, output logic ovf);
    longint       s;
    logic [63:0]  p;
    res = '0;
    ovf = 1'b0;
    case (op)
      4'h0: res = a & b;
      4'h1: res = a | b;
      4'h2: begin
        s   = longint'($signed(a)) + longint'($signed(b));
        res = a + b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h4: res = a ^ b;
      4'h5: res = ~(a | b);
      4'h6: begin
        s   = longint'($signed(a)) - longint'($signed(b));
        res = a - b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h7: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: res = (a < b) ? 32'd1 : 32'd0;
      4'h9: res = b << sh;
      4'hA: res = b >> sh;
      4'hB: res = $unsigned($signed(b) >>> sh);
      4'hC: begin
        p    = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        res  = m_lo;
      end
      4'hD: begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        res = m_lo;
      end
      4'hE: res = m_hi;
      4'hF: res = m_lo;
      default: res = '0;
    endcase
  endtask

  // Present one request at a negedge, then count edges until done (bounded).
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, output int lat);
    start = 1'b1; alu_op = op; first_data = a; second_data = b; shamt = sh;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 100);
    if (!done) check("done_timeout", 64'(lat), 64'd0);
  endtask

  vec_t vecs[$];
  localparam logic [W-1:0] A = 32'h8000_0000;
  localparam logic [W-1:0] B = 32'h7FFF_FFFF;

  initial begin
    int           lat;
    logic [W-1:0] e_res;
    logic         e_ovf;
    int           done_cnt;

    rst_n = 1'b0; start = 1'b0; alu_op = '0; first_data = '0; second_data = '0; shamt = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    run_op(4'hE, '0, '0, '0, lat);
    check("rst_mfhi", 64'(result), 64'd0);
    check("rst_mfhi_zero", 64'(zero), 64'd1);

    // Back-to-back single-cycle sweep; each done must be one cycle after accept.
    vecs.push_back('{"add",  4'h2, A, B, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{"sub",  4'h6, A, B, 5'd0, 32'h0000_0001, 1'b0, 1'b1});
    vecs.push_back('{"and",  4'h0, A, B, 5'd0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{"or",   4'h1, A, B, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{"slt",  4'h7, A, B, 5'd0, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{"sltu", 4'h8, A, B, 5'd0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{"sra",  4'hB, A, A, 5'd4, 32'hF800_0000, 1'b0, 1'b0});
    vecs.push_back('{"srl",  4'hA, A, A, 5'd4, 32'h0800_0000, 1'b0, 1'b0});
    vecs.push_back('{"xor",  4'h4, A, B, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{"nor",  4'h5, A, B, 5'd0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{"sll",  4'h9, B, B, 5'd4, 32'hFFFF_FFF0, 1'b0, 1'b0});
    vecs.push_back('{"op3",  4'h3, A, B, 5'd0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{"addov",4'h2, B, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1});
    foreach (vecs[i]) begin
      start = 1'b1; alu_op = vecs[i].op; first_data = vecs[i].a;
      second_data = vecs[i].b; shamt = vecs[i].sh;
      @(negedge clk);
      check({vecs[i].name, "_done"}, 64'(done), 64'd1);
      check({vecs[i].name, "_res"},  64'(result), 64'(vecs[i].exp_res));
      check({vecs[i].name, "_zero"}, 64'(zero), 64'(vecs[i].exp_zero));
      check({vecs[i].name, "_ovf"},  64'(overflow), 64'(vecs[i].exp_ovf));
    end
    start = 1'b0;
    @(negedge clk);
    check("sweep_done_drop", 64'(done), 64'd0);

    // MULTU with 33-cycle latency, then HI/LO readback (MFHI back-to-back in DONE).
    run_op(4'hC, A, B, '0, lat);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_res", 64'(result), 64'h8000_0000);
    run_op(4'hE, '0, '0, '0, lat);
    check("multu_hi_lat", 64'(lat), 64'd1);
    check("multu_hi", 64'(result), 64'h3FFF_FFFF);
    run_op(4'hF, '0, '0, '0, lat);
    check("multu_lo", 64'(result), 64'h8000_0000);

    // DIVU, then divide by zero.
    run_op(4'hD, A, B, '0, lat);
    check("divu_lat", 64'(lat), 64'd33);
    check("divu_lo", 64'(result), 64'h1);
    run_op(4'hE, '0, '0, '0, lat);
    check("divu_hi", 64'(result), 64'h1);
    run_op(4'hD, A, '0, '0, lat);
    check("div0_lat", 64'(lat), 64'd33);
    check("div0_lo", 64'(result), 64'hFFFF_FFFF);
    run_op(4'hE, '0, '0, '0, lat);
    check("div0_hi", 64'(result), 64'h8000_0000);

    // Busy protection: ADD requests and operand churn during a MULTU are ignored.
    @(negedge clk);
    start = 1'b1; alu_op = 4'hC; first_data = A; second_data = B;
    @(negedge clk);
    check("prot_busy", 64'(busy), 64'd1);
    done_cnt = 0;
    lat = 1;
    for (int c = 0; c < 10; c++) begin
      start = 1'b1; alu_op = 4'h2; first_data = $urandom; second_data = $urandom;
      @(negedge clk);
      lat++;
      if (done) done_cnt++;
    end
    start = 1'b0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("prot_lat", 64'(lat), 64'd33);
    check("prot_res", 64'(result), 64'h8000_0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("prot_extra_done", 64'(done_cnt), 64'd0);
    run_op(4'hE, '0, '0, '0, lat);
    check("prot_hi", 64'(result), 64'h3FFF_FFFF);

    // Reset abandons an in-flight DIVU with no HI/LO update.
    run_op(4'hD, 32'd100, 32'd7, '0, lat);
    start = 1'b1; alu_op = 4'hD; first_data = 32'd1000; second_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    run_op(4'hF, '0, '0, '0, lat);
    check("abort_mflo", 64'(result), 64'd0);
    run_op(4'hE, '0, '0, '0, lat);
    check("abort_mfhi", 64'(result), 64'd0);

    // Randomized ops against the behavioural model.
    for (int n = 0; n < 60; n++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [4:0]   sh;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      sh = 5'($urandom);
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = '0;
        2: a = b + 32'($urandom_range(0, 3));
        default: ;
      endcase
      model_op(op, a, b, sh, e_res, e_ovf);
      run_op(op, a, b, sh, lat);
      check($sformatf("rnd%0d_op%0h_lat", n, op), 64'(lat), ((op == 4'hC) || (op == 4'hD)) ? 64'd33 : 64'd1);
      check($sformatf("rnd%0d_op%0h_res", n, op), 64'(result), 64'(e_res));
      check($sformatf("rnd%0d_op%0h_zero", n, op), 64'(zero), 64'(e_res == '0));
      check($sformatf("rnd%0d_op%0h_ovf", n, op), 64'(overflow), 64'(e_ovf));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
